// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
//
// The security FSM asks for an interval with a start pulse. This block sends
// the interval select to the time-parameter table, reads back the duration in
// seconds, and counts it down using an internal 1 Hz enable derived from the
// system clock. When the count finishes, it pulses expired.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   reset          asynchronous, active-high; clears all state
//   start_timer    1-cycle start/restart request (wins in every state)
//   interval_in    interval requested by the FSM, sampled with start_timer
//   param_sel      registered select driven to the time-parameter table
//   param_value    duration (seconds) returned by the table for param_sel
//   busy           high while loading or counting
//   remaining      seconds left (registered)
//   one_hz_enable  1-cycle pulse at each second boundary while counting
//   expired        1-cycle pulse when the interval completes
// ---------------------------------------------------------------------------
module interval_timer #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int VALUE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_timer,
  input  logic [1:0]         interval_in,
  output logic [1:0]         param_sel,
  input  logic [VALUE_W-1:0] param_value,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining,
  output logic               one_hz_enable,
  output logic               expired
);

  localparam int               DIV_W    = $clog2(CLK_FREQ);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [DIV_W-1:0]   divider;
  logic               tick;
  logic               second_wrap;

  // A second boundary only exists while counting; the divider is held at
  // zero in every other state.
  assign second_wrap = (state == COUNT) && (divider == DIV_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A start request aborts whatever is in progress and
  // goes back to LOAD, so a restart never produces an expiry for the
  // interval it cut short. A zero duration skips counting entirely.
  always_comb begin
    next_state = state;
    if (start_timer) begin
      next_state = LOAD;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        LOAD:    next_state = (param_value != '0) ? COUNT : DONE;
        COUNT:   next_state = (second_wrap && remaining == VALUE_W'(1)) ? DONE : COUNT;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Datapath: table select, seconds divider, remaining count and tick pulse.
  // LOAD exists so the table has one full cycle to settle on the new select
  // before param_value is captured. Later changes to param_value are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      param_sel <= 2'b00;
      divider   <= '0;
      remaining <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (start_timer) begin
        param_sel <= interval_in;
        divider   <= '0;
      end else begin
        case (state)
          LOAD: begin
            remaining <= param_value;
            divider   <= '0;
          end
          COUNT: begin
            if (second_wrap) begin
              divider <= '0;
              tick    <= 1'b1;
              if (remaining != '0) begin
                remaining <= remaining - VALUE_W'(1);
              end
            end else begin
              divider <= divider + DIV_W'(1);
            end
          end
          default: begin
            divider <= '0;
          end
        endcase
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy    = (state == LOAD) || (state == COUNT);
    expired = (state == DONE);
  end

  assign one_hz_enable = tick;

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Consumer side of the security system's time-parameter lookup. On a start request it drives the interval select to the parameter table and reads back the 4-bit duration in seconds.
- Counts that many seconds using an internal 1 Hz enable derived from the system clock, then flags expiry to the anti-theft FSM.
- Sits between the main security FSM (start/interval/expired) and the combinational time-parameter table (select out, value in).

Parameters:
- CLK_FREQ, 25_000_000, clock cycles per second. Divider wraps at CLK_FREQ-1. Minimum 2. Bench uses 4.
- VALUE_W, 4, width of the duration value and the remaining-count.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_timer  in  1  1-cycle start/restart request
- interval_in  in  2  interval requested by the FSM (00 arm delay, 01 driver delay, 10 passenger delay, 11 alarm on)
- param_sel  out  2  registered select driven to the time-parameter table
- param_value  in  VALUE_W  duration in seconds returned by the table for param_sel (combinational)
- busy  out  1  high in LOAD and COUNT
- remaining  out  VALUE_W  seconds left (registered)
- one_hz_enable  out  1  1-cycle pulse at each second boundary while counting
- expired  out  1  1-cycle pulse when the interval completes

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE, param_sel=00, remaining=0, divider=0
  - busy=0, one_hz_enable=0, expired=0
- FSM states: IDLE, LOAD, COUNT, DONE. start_timer has priority in every state.
- start_timer=1 at edge N (any state): param_sel<=interval_in, divider<=0, state<=LOAD. This aborts any running count with no expiry.
- LOAD (one cycle, lets the table settle on the new param_sel):
  - At edge N+1: remaining<=param_value, divider<=0.
  - State<=COUNT if param_value!=0; otherwise state<=DONE with expired<=1.
- COUNT:
  - Each cycle divider increments.
  - When divider==CLK_FREQ-1: divider<=0, one_hz_enable<=1 for that next cycle, remaining<=remaining-1.
  - If remaining==1 at that wrap: remaining<=0, state<=DONE, expired<=1.
- DONE (one cycle): expired=1, busy=0. Next state IDLE, or LOAD if start_timer is high; expired still pulses in that case.
- IDLE: holds remaining=0, param_sel keeps its last value, no pulses.
- Latency: start sampled at edge N gives expired high for the cycle after edge N+1+V*CLK_FREQ, where V is the loaded value. V=0 gives expired after edge N+1.
- Decrement never wraps below 0. Divider width is ceil(log2(CLK_FREQ)).
- param_value is sampled only in LOAD; changes during COUNT are ignored.
- interval_in is sampled only with start_timer.

Test Plan:
- Reset behaviour, CLK_FREQ=4, table 00→6, 01→8, 10→15, 11→10. Assert reset mid-COUNT → all outputs 0 and state IDLE immediately (asynchronous). No expired after release.
- Basic count: start with interval_in=00 at edge 0 → param_sel=00 after edge 0, remaining=6 after edge 1. Six one_hz_enable pulses 4 cycles apart, remaining steps 5..0, expired high exactly in the cycle after edge 25. busy=0 from then on.
- Full-range value: interval 10 → remaining=15 and expired after edge 61. Interval 11 → expired after edge 41, with exactly 10 ticks.
- Restart mid-count: start interval 01, then at remaining=3 start interval 00 → no expired pulse from the first run, remaining reloads to 6, and expired comes 1+24 cycles after the restart edge.
- Zero duration: table forced to return 0 → expired after edge 1, no one_hz_enable, busy high for one cycle only.
- Start coincident with DONE: expired pulses and the FSM enters LOAD. The second interval completes normally. Changing param_value during COUNT does not alter remaining.
